ser2: RTL
=========

# ser2

Two-lane byte-to-serial transmitter with per-lane input buffering. It is the transmit-side counterpart of the two-lane serial dispatcher: each lane accepts 8-bit words with a write strobe, holds them in a small FIFO that reports almost-full, and shifts them out MSB-first, one bit per clock, with a per-lane valid qualifier. The block sits between the byte-side producers and the serial links that feed the dispatcher's `in1`/`in2`.

## Interface
- `DATA_WIDTH`, 8, word width and bits per serial frame.
- `FIFO_DEPTH`, 4, entries per lane FIFO; must be a power of two, at least 2.
- `ALMOST_FULL_LVL`, 3, occupancy at or above which `almost_full_fN` is asserted; range 1..`FIFO_DEPTH`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state at the next `clk` edge.
- `in1`, `in2`  in  `DATA_WIDTH`  lane 1 / lane 2 write data.
- `write1`, `write2`  in  1  write strobe per lane; sampled each edge.
- `almost_full_f1`, `almost_full_f2`  out  1  lane occupancy ≥ `ALMOST_FULL_LVL`.
- `err1`, `err2`  out  1  sticky overflow flag per lane; cleared only by reset.
- `out1`, `out2`  out  1  serial data per lane, MSB first.
- `valid1`, `valid2`  out  1  high while the corresponding `outN` carries a frame bit.

## Operation
- Lanes are fully independent and identical. No shared state.
- Per-lane FIFO: circular buffer with rd/wr pointers wrapping modulo `FIFO_DEPTH`, plus a count of width clog2(`FIFO_DEPTH`)+1.
- Write accepted when `writeN`=1 and (count < `FIFO_DEPTH` or a pop happens on the same edge). Write while full with no same-edge pop: data dropped, pointers unchanged, `errN` set to 1.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- `almost_full_fN` is registered and reflects the count after each edge.
- Serializer FSM, two states:
  - IDLE: `validN`=0, `outN`=0. If count ≠ 0, pop the head word into an 8-bit shift register, clear the bit counter, go to SHIFT.
  - SHIFT: `outN` = shift-register MSB, `validN`=1. Each edge shifts left by one and increments the bit counter.
  - When the bit counter = `DATA_WIDTH`-1 and count ≠ 0, load the next word on that same edge. Frames run back-to-back with no gap.
  - When the bit counter = `DATA_WIDTH`-1 and count = 0, return to IDLE.
- The serializer pops only at IDLE→SHIFT and at back-to-back reload.
- Reset values: `outN`=0, `validN`=0, `almost_full_fN`=0, `errN`=0, FIFOs empty, FSMs in IDLE. Reset mid-frame aborts the frame, with no partial resume, and discards FIFO contents.

## Timing
- Write sampled at edge k: count = 1 after edge k.
- First bit (MSB) appears on `outN` with `validN`=1 after edge k+1.
- Bits 7..0 occupy the 8 cycles following edges k+1..k+8.
- The next pop happens at edge k+9.
- The serializer drains one word per 8 cycles. Sustained writes faster than this fill the FIFO.
- `almost_full_fN` and `errN` update on the same edge as the count change or dropped write that causes them.
- Reset takes priority over all writes and pops on the same edge.

## Test plan
- Reset, then hold `write1`=`write2`=0 for 10 cycles -> all outputs 0 every cycle.
- `in1`=8'hA5 with `write1` pulsed for one cycle -> starting one cycle later, `out1` = 1,0,1,0,0,1,0,1 with `valid1`=1 for exactly 8 cycles, then 0. Lane 2 stays idle.
- `in2`=8'h3C, then 8'hFF, written on consecutive cycles -> `valid2` high for 16 consecutive cycles. `out2` = 0,0,1,1,1,1,0,0 then 1×8.
- Write lane 1 on 6 consecutive cycles (b0..b5) from empty, default params:
  - `almost_full_f1` rises after the 4th write.
  - count reaches 4 after the 5th write.
  - b5 is dropped and `err1`=1.
  - b0..b4 are serialized in order with no gaps (40 bits).
  - `err1` stays 1 until reset.
- Assert reset during bit 3 of a lane-1 frame while 2 words are queued -> next cycle `out1`=`valid1`=0, `almost_full_f1`=0. A subsequent single write yields a clean 8-bit frame of the new word only.
- Simultaneous writes 8'h81 on lane 1 and 8'h7E on lane 2 -> both frames start on the same cycle, bit-for-bit independent. Lane 2 is unaffected by a lane-1 overflow induced afterwards.

Source files
------------

// File: rtl/ser2.sv
// ser2: two-lane byte-to-serial transmitter.
// Each lane buffers words in a small FIFO and shifts them out MSB-first,
// one bit per clock, with a valid qualifier. Lanes share no state.

module ser2_lane #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int ALMOST_FULL_LVL = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  write,
    output logic                  almost_full,
    output logic                  err,
    output logic                  out,
    output logic                  valid
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LVL);
    localparam logic [BW-1:0] LAST_C  = BW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic                  last_bit;
    logic                  pop;
    logic                  accept;

    // The serial bit is always the shift-register MSB; the register is
    // cleared whenever the lane goes idle, so out reads 0 between frames.
    assign out = shreg[DATA_WIDTH-1];

    // Pop on idle start or on the last bit of a frame (back-to-back reload).
    // A same-edge pop frees a slot, so a write to a full FIFO is still taken.
    always_comb begin
        last_bit   = (state == SHIFT) && (bit_cnt == LAST_C);
        pop        = (count != '0) && ((state == IDLE) || last_bit);
        accept     = write && ((count != DEPTH_C) || pop);
        count_next = count;
        if (accept && !pop) begin
            count_next = count + CW'(1);
        end else if (!accept && pop) begin
            count_next = count - CW'(1);
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy, almost-full and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (write && !accept) begin
                err <= 1'b1;
            end
            count       <= count_next;
            almost_full <= (count_next >= AF_C);
        end
    end

    // Serializer: load on pop, shift one bit per clock, idle when drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        bit_cnt <= '0;
                        valid   <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        if (pop) begin
                            shreg   <= mem[rd_ptr];
                            bit_cnt <= '0;
                            valid   <= 1'b1;
                        end else begin
                            shreg   <= '0;
                            bit_cnt <= '0;
                            valid   <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

module ser2 #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int ALMOST_FULL_LVL = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic                  write1,
    input  logic                  write2,
    output logic                  almost_full_f1,
    output logic                  almost_full_f2,
    output logic                  err1,
    output logic                  err2,
    output logic                  out1,
    output logic                  out2,
    output logic                  valid1,
    output logic                  valid2
);
    ser2_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ALMOST_FULL_LVL(ALMOST_FULL_LVL)
    ) u_lane1 (
        .clk(clk), .reset(reset), .din(in1), .write(write1),
        .almost_full(almost_full_f1), .err(err1), .out(out1), .valid(valid1)
    );

    ser2_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ALMOST_FULL_LVL(ALMOST_FULL_LVL)
    ) u_lane2 (
        .clk(clk), .reset(reset), .din(in2), .write(write2),
        .almost_full(almost_full_f2), .err(err2), .out(out2), .valid(valid2)
    );
endmodule
